seq_divider: RTL and testbench



---
 rtl/div_pkg.sv | 12 +
 rtl/cond_sub.sv | 13 +
 rtl/seq_divider.sv | 120 ++++++++++++
 tb/tb_seq_divider.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

    localparam int unsigned DIV_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/cond_sub.sv
// Combinational (W+1)-bit trial subtractor; borrow is the sign of the difference.
module cond_sub #(
    parameter int unsigned W = 4
) (
    input  logic [W:0]   a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         borrow
);

    assign {borrow, diff} = a - {1'b0, b};

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring unsigned divider: one quotient bit per clock, start/busy/done handshake.
module seq_divider
    import div_pkg::*;
#(
    parameter int unsigned N = DIV_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int unsigned CW = $clog2(N);

    div_state_t    state_q, state_d;
    logic [N-1:0]  rem_q;
    logic [N-1:0]  sr_q;
    logic [N-1:0]  dvs_q;
    logic [CW-1:0] cnt_q;

    logic          load, step, last;
    logic [N:0]    shifted;
    logic [N-1:0]  trial;
    logic          borrow;
    logic [N-1:0]  rem_nxt;
    logic [N-1:0]  sr_nxt;

    // Working remainder stays below 2^N (below the divisor, or the dividend when dividing by 0),
    // so only the shifted-in word needs the extra trial bit.
    assign shifted = {rem_q, sr_q[N-1]};

    cond_sub #(.W(N)) u_cond_sub (
        .a      (shifted),
        .b      (dvs_q),
        .diff   (trial),
        .borrow (borrow)
    );

    assign rem_nxt = borrow ? shifted[N-1:0] : trial;
    assign sr_nxt  = {sr_q[N-2:0], ~borrow};

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        last    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    load    = 1'b1;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt_q == '0) begin
                    last    = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_d = RUN;
                    load    = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Working registers and published results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q       <= '0;
            sr_q        <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (load) begin
            dvs_q       <= divisor;
            sr_q        <= dividend;
            rem_q       <= '0;
            cnt_q       <= CW'(N - 1);
            div_by_zero <= 1'b0;
        end else if (step) begin
            rem_q <= rem_nxt;
            sr_q  <= sr_nxt;
            cnt_q <= cnt_q - CW'(1);
            if (last) begin
                quotient    <= sr_nxt;
                remainder   <= rem_nxt;
                div_by_zero <= (dvs_q == '0);
            end
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed and exhaustive self-checking bench for seq_divider at N=4.
module tb_seq_divider;

    localparam int unsigned N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] dividend = '0;
    logic [N-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    int total = 0;
    int bad = 0;

    logic [N-1:0] prev_q = '0;
    logic [N-1:0] prev_r = '0;

    always #5 clk = ~clk;

    seq_divider #(.N(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Array multiplier reference: sum of AND partial products.
    function automatic logic [7:0] braun_mul(input logic [3:0] a, input logic [3:0] b);
        logic [7:0] acc;
        acc = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                acc = acc + (8'(a[i] & b[j]) << (i + j));
            end
        end
        return acc;
    endfunction

    task automatic run_div(input logic [3:0] a, input logic [3:0] b, input bit inject,
                           input logic [3:0] eq, input logic [3:0] er, input logic edbz,
                           input string tag);
        int lat;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_dbz_clr"}, 32'(div_by_zero), 32'd0);
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) begin
                check({tag, "_hold_q"}, 32'(quotient), 32'(prev_q));
                check({tag, "_hold_r"}, 32'(remainder), 32'(prev_r));
            end
            if (inject && lat == 1) begin
                @(negedge clk);
                dividend = 4'd12;
                divisor  = 4'd5;
                start    = 1'b1;
            end else if (inject && lat == 2) begin
                @(negedge clk);
                start = 1'b0;
            end
        end
        check({tag, "_lat"}, 32'(lat), 32'(N));
        check({tag, "_q"}, 32'(quotient), 32'(eq));
        check({tag, "_r"}, 32'(remainder), 32'(er));
        check({tag, "_dbz"}, 32'(div_by_zero), 32'(edbz));
        prev_q = eq;
        prev_r = er;
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, 32'(done), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int   cyc;
        logic seen;
        logic [3:0] a, b, eq, er;

        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_q", 32'(quotient), 32'd0);
        check("rst_r", 32'(remainder), 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_div(4'd13, 4'd3, 1'b0, 4'd4, 4'd1, 1'b0, "d13_3");
        run_div(4'd7, 4'd0, 1'b0, 4'd15, 4'd7, 1'b1, "d7_0");
        run_div(4'd15, 4'd1, 1'b0, 4'd15, 4'd0, 1'b0, "d15_1");
        run_div(4'd0, 4'd5, 1'b0, 4'd0, 4'd0, 1'b0, "d0_5");
        run_div(4'd9, 4'd9, 1'b0, 4'd1, 4'd0, 1'b0, "d9_9");
        run_div(4'd5, 4'd9, 1'b0, 4'd0, 4'd5, 1'b0, "d5_9");
        run_div(4'd14, 4'd4, 1'b1, 4'd3, 4'd2, 1'b0, "d14_4_inj");

        // Reset asserted in the second RUN cycle
        @(negedge clk);
        dividend = 4'd13;
        divisor  = 4'd3;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_q", 32'(quotient), 32'd0);
        check("abort_r", 32'(remainder), 32'd0);
        check("abort_dbz", 32'(div_by_zero), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        check("abort_no_done", 32'(seen), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        prev_q = '0;
        prev_r = '0;
        run_div(4'd11, 4'd2, 1'b0, 4'd5, 4'd1, 1'b0, "d11_2");

        // All 256 operand pairs, each next one issued from DONE
        @(negedge clk);
        dividend = '0;
        divisor  = '0;
        start    = 1'b1;
        for (int k = 0; k < 256; k++) begin
            a = 4'(k >> 4);
            b = 4'(k);
            @(posedge clk);
            #1;
            @(negedge clk);
            if (k < 255) begin
                dividend = 4'((k + 1) >> 4);
                divisor  = 4'(k + 1);
            end else begin
                start = 1'b0;
            end
            cyc = 0;
            while (!done && cyc < 20) begin
                @(posedge clk);
                #1;
                cyc++;
            end
            eq = (b == 4'd0) ? 4'd15 : 4'(a / b);
            er = (b == 4'd0) ? a : 4'(a % b);
            check($sformatf("ex_lat_%0d_%0d", a, b), 32'(cyc), 32'(N));
            check($sformatf("ex_q_%0d_%0d", a, b), 32'(quotient), 32'(eq));
            check($sformatf("ex_r_%0d_%0d", a, b), 32'(remainder), 32'(er));
            check($sformatf("ex_dbz_%0d_%0d", a, b), 32'(div_by_zero), 32'(b == 4'd0));
            if (b != 4'd0) begin
                check($sformatf("ex_trip_%0d_%0d", a, b),
                      32'(braun_mul(quotient, b) + 8'(remainder)), 32'(a));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
